// File: rtl/snn_config_loader.sv
// Byte-serial loader that assembles the SNN threshold/decay/refractory/weight/delay buses.
// Optional trailing XOR checksum byte is enabled by defining SNN_CFG_CHECKSUM_EN.
module snn_config_loader #(
  parameter int unsigned WEIGHT_BYTES = 144,
  parameter int unsigned DELAY_BYTES  = 72,
  parameter int unsigned PARAM_BYTES  = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      load_start_i,
  input  logic [7:0]                data_in_i,
  input  logic                      data_valid_i,
  output logic [7:0]                threshold_o,
  output logic [7:0]                decay_o,
  output logic [7:0]                refractory_period_o,
  output logic [8*WEIGHT_BYTES-1:0] weights_o,
  output logic [8*DELAY_BYTES-1:0]  delays_o,
  output logic                      config_valid_o,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          byte_count_o,
  output logic                      load_error_o
);

  localparam int unsigned TotalBytes = PARAM_BYTES + WEIGHT_BYTES + DELAY_BYTES;
  localparam int unsigned DelayBase  = PARAM_BYTES + WEIGHT_BYTES;
`ifdef SNN_CFG_CHECKSUM_EN
  localparam int unsigned LastIdx = TotalBytes;
`else
  localparam int unsigned LastIdx = TotalBytes - 1;
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [7:0]                threshold_q, decay_q, refractory_q;
  logic [8*WEIGHT_BYTES-1:0] weights_q;
  logic [8*DELAY_BYTES-1:0]  delays_q;
  logic                      accept;
  logic                      last_byte;
  logic                      csum_ok;
  int unsigned               k;

  // A restart in the same cycle as a valid byte wins; the byte is dropped.
  assign accept    = (state_q == StLoad) && data_valid_i && !load_start_i;
  assign last_byte = accept && (cnt_q == CNT_W'(LastIdx));
  assign k         = 32'(cnt_q);

`ifdef SNN_CFG_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       err_q, err_d;

  assign csum_ok = (csum_q == data_in_i);

  always_comb begin
    csum_d = csum_q;
    err_d  = err_q;
    if (load_start_i) begin
      csum_d = 8'h00;
      err_d  = 1'b0;
    end else if (accept) begin
      if (k < TotalBytes) csum_d = csum_q ^ data_in_i;
      if (last_byte && !csum_ok) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      csum_q <= 8'h00;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end

  assign load_error_o = err_q;
`else
  assign csum_ok      = 1'b1;
  assign load_error_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (load_start_i) state_d = StLoad;
      end
      StLoad: begin
        if (load_start_i)   state_d = StLoad;
        else if (last_byte) state_d = csum_ok ? StDone : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_start_i) cnt_d = '0;
    else if (accept)  cnt_d = cnt_q + 1'b1;
  end

  // Outputs
  always_comb begin
    busy_o         = (state_q == StLoad);
    config_valid_o = (state_q == StDone);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      threshold_q  <= 8'h00;
      decay_q      <= 8'h00;
      refractory_q <= 8'h00;
      weights_q    <= '0;
      delays_q     <= '0;
    end else if (accept) begin
      if (k == 0)               threshold_q  <= data_in_i;
      else if (k == 1)          decay_q      <= data_in_i;
      else if (k == 2)          refractory_q <= data_in_i;
      else if (k < DelayBase)   weights_q[8*(k-PARAM_BYTES) +: 8] <= data_in_i;
      else if (k < TotalBytes)  delays_q[8*(k-DelayBase) +: 8]    <= data_in_i;
    end
  end

  assign threshold_o         = threshold_q;
  assign decay_o             = decay_q;
  assign refractory_period_o = refractory_q;
  assign weights_o           = weights_q;
  assign delays_o            = delays_q;
  assign byte_count_o        = cnt_q;

endmodule

// File: tb/tb_snn_config_loader.sv
// Self-checking bench for snn_config_loader against a byte-array model of the config stream.
module tb_snn_config_loader;
  localparam int unsigned W = 144;
  localparam int unsigned D = 72;
  localparam int unsigned P = 3;
  localparam int unsigned T = P + W + D;
`ifdef SNN_CFG_CHECKSUM_EN
  localparam int unsigned Cs = 1;
`else
  localparam int unsigned Cs = 0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           load_start;
  logic [7:0]     data_in;
  logic           data_valid;
  logic [7:0]     threshold, decay, refractory_period;
  logic [8*W-1:0] weights;
  logic [8*D-1:0] delays;
  logic           config_valid, busy, load_error;
  logic [7:0]     byte_count;

  snn_config_loader #(
    .WEIGHT_BYTES(W),
    .DELAY_BYTES (D),
    .PARAM_BYTES (P),
    .CNT_W       (8)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .load_start_i       (load_start),
    .data_in_i          (data_in),
    .data_valid_i       (data_valid),
    .threshold_o        (threshold),
    .decay_o            (decay),
    .refractory_period_o(refractory_period),
    .weights_o          (weights),
    .delays_o           (delays),
    .config_valid_o     (config_valid),
    .busy_o             (busy),
    .byte_count_o       (byte_count),
    .load_error_o       (load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: config bytes in stream order plus load progress.
  logic [7:0] mdl [T];
  int         m_cnt;
  bit         m_load, m_done, m_err;
  logic [7:0] m_xor;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_bad_w();
    for (int j = 0; j < int'(W); j++) if (weights[8*j +: 8] !== mdl[P+j]) return j;
    return -1;
  endfunction

  function automatic int first_bad_d();
    for (int j = 0; j < int'(D); j++) if (delays[8*j +: 8] !== mdl[P+W+j]) return j;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(T); i++) mdl[i] = 8'h00;
    m_cnt = 0; m_load = 0; m_done = 0; m_err = 0; m_xor = 8'h00;
  endtask

  task automatic model_step(input bit s, input bit v, input logic [7:0] d);
    bit ok;
    ok = 1'b1;
    if (s) begin
      m_load = 1; m_done = 0; m_err = 0; m_cnt = 0; m_xor = 8'h00;
    end else if (m_load && v) begin
      if (m_cnt == int'(T)) ok = (d == m_xor);
      else begin
        mdl[m_cnt] = d;
        m_xor ^= d;
      end
      m_cnt++;
      if (m_cnt == int'(T + Cs)) begin
        m_load = 0; m_done = ok; m_err = !ok;
      end
    end
  endtask

  task automatic check_all();
    check("threshold", 32'(threshold), 32'(mdl[0]));
    check("decay", 32'(decay), 32'(mdl[1]));
    check("refractory", 32'(refractory_period), 32'(mdl[2]));
    check("weights_first_bad_byte", first_bad_w(), -1);
    check("delays_first_bad_byte", first_bad_d(), -1);
    check("config_valid", 32'(config_valid), 32'(m_done));
    check("busy", 32'(busy), 32'(m_load));
    check("byte_count", 32'(byte_count), m_cnt);
    check("load_error", 32'(load_error), 32'(m_err));
  endtask

  task automatic cycle(input bit s, input bit v, input logic [7:0] d);
    load_start = s; data_valid = v; data_in = d;
    @(posedge clk);
    model_step(s, v, d);
    #1;
    check_all();
  endtask

  // mode 0: byte k = k, mode 1: all A5, mode 2: random. Random idle gaps between bytes.
  task automatic load_full(input int mode, input bit corrupt);
    logic [7:0] x, b;
    x = 8'h00;
    cycle(1'b1, 1'b1, 8'h77);
    for (int k = 0; k < int'(T + Cs); k++) begin
      if ($urandom_range(3) == 0) cycle(1'b0, 1'b0, 8'($urandom));
      if (k == int'(T)) b = corrupt ? ~x : x;
      else if (mode == 0) b = 8'(k);
      else if (mode == 1) b = 8'hA5;
      else b = 8'($urandom);
      if (k < int'(T)) x ^= b;
      cycle(1'b0, 1'b1, b);
    end
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();

    // Bytes offered in IDLE are ignored
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'hFF);

    // Incrementing pattern with exact field placement
    load_full(0, 1'b0);
    check("thr_const", 32'(threshold), 32'h00);
    check("decay_const", 32'(decay), 32'h01);
    check("refr_const", 32'(refractory_period), 32'h02);
    check("w_lo_const", 32'(weights[7:0]), 32'h03);
    check("w_hi_const", 32'(weights[8*W-1 -: 8]), 32'h92);
    check("d_lo_const", 32'(delays[7:0]), 32'h93);
    check("d_hi_const", 32'(delays[8*D-1 -: 8]), 32'hDA);
    check("count_const", 32'(byte_count), T + Cs);

    // Extra bytes in DONE are dropped
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00);

    // Partial load, restart, full A5 load
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, 8'($urandom));
    load_full(1, 1'b0);

    // Random content loads
    for (int r = 0; r < 2; r++) load_full(2, 1'b0);

`ifdef SNN_CFG_CHECKSUM_EN
    load_full(2, 1'b1);
    check("csum_err_flag", 32'(load_error), 32'h1);
    cycle(1'b0, 1'b1, 8'h5A);
    cycle(1'b1, 1'b0, 8'h00);
    check("csum_err_cleared", 32'(load_error), 32'h0);
    load_full(2, 1'b0);
`endif

    // Asynchronous reset in the middle of a cycle after 100 bytes
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 8'($urandom));
    load_start = 1'b0; data_valid = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
    cycle(1'b0, 1'b1, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_config_loader.md
Name: snn_config_loader

Overview:
Byte-serial configuration loader that sits directly upstream of the SNN-with-delays top level. It accepts a stream of 8-bit configuration bytes over a narrow pin interface and assembles the wide parallel configuration buses that the network consumes: threshold, decay, refractory period, packed weights and packed delays. It tracks load progress with a small FSM and reports when the configuration is complete and stable, so that the network enable can be gated on it.

Parameters:
WEIGHT_BYTES, 144, number of weight bytes (weights bus = 8*WEIGHT_BYTES = 1152 bits)
DELAY_BYTES, 72, number of delay bytes (delays bus = 8*DELAY_BYTES = 576 bits)
PARAM_BYTES, 3, scalar parameter bytes (threshold, decay, refractory_period), fixed at 3
CNT_W, 8, byte-counter width; must satisfy 2^CNT_W > PARAM_BYTES+WEIGHT_BYTES+DELAY_BYTES (+1 with checksum)

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
load_start  in  1  single-cycle pulse; begins (or restarts) a load
data_in  in  8  configuration byte
data_valid  in  1  data_in is valid this cycle; one byte accepted per cycle when high in LOAD
threshold  out  8  firing threshold
decay  out  8  decay value
refractory_period  out  8  refractory period
weights  out  8*WEIGHT_BYTES  packed weights
delays  out  8*DELAY_BYTES  packed delay fields, {delay_enable, delay_value[2:0]} nibbles
config_valid  out  1  full configuration loaded and stable
busy  out  1  high while in LOAD
byte_count  out  CNT_W  bytes accepted in the current load
load_error  out  1  checksum failure flag (see Optional Feature)

Behaviour:
- Reset (async, active-high): all outputs and storage go to 0; FSM -> IDLE. Reset mid-load discards partial data.
- Total bytes T = PARAM_BYTES+WEIGHT_BYTES+DELAY_BYTES = 219.
- Byte order on the stream, index k = byte_count at acceptance:
  - k=0 -> threshold; k=1 -> decay; k=2 -> refractory_period.
  - k=3..3+WEIGHT_BYTES-1 -> weights[8j+7:8j], j = k-3 (LSB byte first).
  - next DELAY_BYTES -> delays[8j+7:8j], j = k-3-WEIGHT_BYTES.
- All writes are registered. A byte accepted in cycle n is visible on its output in cycle n+1.
- FSM:
  - IDLE: busy=0. load_start -> LOAD, byte_count cleared to 0, config_valid cleared to 0, load_error cleared to 0. data_valid is ignored.
  - LOAD: busy=1. Each cycle with data_valid=1 writes the byte and increments byte_count. On acceptance of the byte with k=T-1 -> DONE. config_valid rises the next cycle, i.e. the same edge that writes the last byte.
  - DONE: busy=0, config_valid=1, outputs held. data_valid is ignored (extra bytes are dropped). load_start -> LOAD as from IDLE.
- load_start in LOAD restarts: byte_count=0, config_valid stays 0. Previously written bytes remain on the outputs until overwritten.
- load_start and data_valid in the same cycle: the restart wins and that byte is not accepted.
- byte_count saturates at T in DONE and never wraps.
- Outputs change only on accepted bytes. There is no glitching of unrelated fields.

Optional Feature:
- Macro SNN_CFG_CHECKSUM_EN.
- Defined:
  - Stream carries one extra trailing byte at k=T: the XOR of all T preceding bytes. The loader keeps a running XOR and leaves LOAD on acceptance of byte k=T.
  - Match: -> DONE, config_valid=1 next cycle, load_error=0.
  - Mismatch: -> IDLE, config_valid=0, load_error=1; load_error holds until the next load_start or reset.
- Undefined: no trailing byte; the load completes at k=T-1; load_error is tied to 0.

Test Plan:
- Reset, then load_start and 219 bytes with byte k=k[7:0] (checksum 8'h?? computed by bench if enabled) -> threshold=00, decay=01, refractory_period=02, weights[7:0]=03, weights[1151:1144]=92, delays[7:0]=93, delays[575:568]=DA; config_valid=1 exactly one cycle after the final byte; busy=0; byte_count=219.
- data_valid pulses in IDLE with data 8'hFF -> no output changes, byte_count=0, config_valid=0.
- Load 50 bytes, pulse load_start, then full 219-byte load of 8'hA5 -> all fields 8'hA5, byte_count=219, config_valid=1.
- Assert reset asynchronously (mid-cycle) after 100 bytes -> all outputs 0 immediately, FSM IDLE, busy=0.
- After DONE, drive 10 more data_valid bytes of 8'h00 -> configuration unchanged, config_valid stays 1.
- With SNN_CFG_CHECKSUM_EN: full load with a corrupted checksum byte -> load_error=1, config_valid=0, FSM IDLE; next load_start clears load_error.
